// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store initiator for the RV32
// data-memory port. Loads read a word and extend it. Word stores write
// byte-swapped data. Byte/half stores do read-modify-write (RD, GAP, WR).
// Optional feature: define MEM_ACCESS_ALIGN_CHECK_EN to reject misaligned
// half/word accesses with resp_err and no memory command.
module mem_access_unit #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  mem_ctrl_input,
    output logic [31:0] address,
    output logic [31:0] w_data,
    input  logic [31:0] read_data
);

    localparam int unsigned     CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_GAP  = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [1:0] CTRL_NONE  = 2'b00;
    localparam logic [1:0] CTRL_READ  = 2'b10;
    localparam logic [1:0] CTRL_WRITE = 2'b01;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    // Responder stores w_data[7:0] at a+3, so swapping bytes yields little-endian memory
    function automatic logic [31:0] byte_swap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    // Sign/zero extension of the low byte or half of the fetched word
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic [31:0] res;
        case (size)
            SZ_BYTE: res = uns ? {24'd0, word[7:0]}  : {{24{word[7]}}, word[7:0]};
            SZ_HALF: res = uns ? {16'd0, word[15:0]} : {{16{word[15]}}, word[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the low byte or half of the fetched word with store data
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [15:0] wdata,
                                                input logic [1:0]  size);
        logic [31:0] res;
        if (size == SZ_BYTE) begin
            res = {word[31:8], wdata[7:0]};
        end else begin
            res = {word[31:16], wdata};
        end
        return res;
    endfunction

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             write_q, write_d;
    logic [1:0]       size_q, size_d;
    logic             unsigned_q, unsigned_d;
    logic [15:0]      wdata_q, wdata_d;
    logic [31:0]      rd_word_q, rd_word_d;
    logic [31:0]      address_q, address_d;
    logic [31:0]      w_data_q, w_data_d;
    logic [31:0]      resp_rdata_q, resp_rdata_d;
    logic             resp_err_q, resp_err_d;
    logic             resp_valid_q, resp_valid_d;
    logic             req_ready_q, req_ready_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic             misalign_c;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    // Half at odd address or word not on a 4-byte boundary
    always_comb begin
        misalign_c = ((req_size == SZ_HALF) && req_addr[0]) ||
                     (req_size[1] && (req_addr[1:0] != 2'b00));
    end
`else
    // No alignment checking: misaligned accesses touch the literal bytes
    always_comb begin
        misalign_c = 1'b0;
    end
`endif

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        wdata_d      = wdata_q;
        rd_word_d    = rd_word_q;
        address_d    = address_q;
        w_data_d     = w_data_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d      = req_write;
                    size_d       = req_size;
                    unsigned_d   = req_unsigned;
                    wdata_d      = req_wdata[15:0];
                    address_d    = req_addr;
                    resp_rdata_d = 32'd0;
                    resp_err_d   = 1'b0;
                    cnt_d        = '0;
                    if (misalign_c) begin
                        resp_err_d = 1'b1;
                        address_d  = address_q;
                        state_d    = ST_DONE;
                    end else if (!req_write || !req_size[1]) begin
                        // Loads and sub-word stores both start with a read
                        state_d = ST_RD;
                    end else begin
                        w_data_d = byte_swap(req_wdata);
                        state_d  = ST_WR;
                    end
                end
            end
            ST_RD: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    rd_word_d = read_data;
                    if (write_q) begin
                        state_d = ST_GAP;
                    end else begin
                        resp_rdata_d = load_extend(read_data, size_q, unsigned_q);
                        state_d      = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                w_data_d = byte_swap(store_merge(rd_word_q, wdata_q, size_q));
                cnt_d    = '0;
                state_d  = ST_WR;
            end
            ST_WR: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Command encoding follows the next state so it can never be 11
        if (state_d == ST_RD) begin
            ctrl_d = CTRL_READ;
        end else if (state_d == ST_WR) begin
            ctrl_d = CTRL_WRITE;
        end else begin
            ctrl_d = CTRL_NONE;
        end
        resp_valid_d = (state_d == ST_DONE);
        req_ready_d  = (state_d == ST_IDLE);
    end

    // State and output registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            wdata_q      <= 16'd0;
            rd_word_q    <= 32'd0;
            address_q    <= 32'd0;
            w_data_q     <= 32'd0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            ctrl_q       <= CTRL_NONE;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            wdata_q      <= wdata_d;
            rd_word_q    <= rd_word_d;
            address_q    <= address_d;
            w_data_q     <= w_data_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            resp_valid_q <= resp_valid_d;
            req_ready_q  <= req_ready_d;
            ctrl_q       <= ctrl_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_err       = resp_err_q;
    assign mem_ctrl_input = ctrl_q;
    assign address        = address_q;
    assign w_data         = w_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (MEM_LAT=1 and MEM_LAT=3), each
// with a byte-array memory responder. Expected responses go into a
// scoreboard queue, and a monitor pops and compares them on every resp_valid.
module tb_mem_access_unit;

    logic        clk;
    logic        reset_n;
    logic        tb_init;
    logic        rv1, rv3;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rdy1, rsp_v1, err1;
    logic [31:0] rsp_d1, addr1, wd1, rdd1;
    logic [1:0]  ctrl1;
    logic        rdy3, rsp_v3, err3;
    logic [31:0] rsp_d3, addr3, wd3, rdd3;
    logic [1:0]  ctrl3;

    logic [7:0]  mem1 [256];
    logic [7:0]  mem3 [256];

    typedef struct {
        int          id;
        int          tn;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        sb[$];
    logic [1:0]  trace[$];
    bit          tr_on;
    int          tr_sel;
    int          cyc;
    int          total;
    int          bad;
    bit          ctrl11_seen;
    bit          busy_ready_seen;

    mem_access_unit #(.MEM_LAT(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(rv1), .req_ready(rdy1), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rsp_v1), .resp_rdata(rsp_d1), .resp_err(err1),
        .mem_ctrl_input(ctrl1), .address(addr1), .w_data(wd1),
        .read_data(rdd1)
    );

    mem_access_unit #(.MEM_LAT(3)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(rv3), .req_ready(rdy3), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rsp_v3), .resp_rdata(rsp_d3), .resp_err(err3),
        .mem_ctrl_input(ctrl3), .address(addr3), .w_data(wd3),
        .read_data(rdd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Responder read: {m[a+3],m[a+2],m[a+1],m[a]}
    assign rdd1 = {mem1[8'(addr1[7:0] + 8'd3)], mem1[8'(addr1[7:0] + 8'd2)],
                   mem1[8'(addr1[7:0] + 8'd1)], mem1[addr1[7:0]]};
    assign rdd3 = {mem3[8'(addr3[7:0] + 8'd3)], mem3[8'(addr3[7:0] + 8'd2)],
                   mem3[8'(addr3[7:0] + 8'd1)], mem3[addr3[7:0]]};

    // Responder write: w_data[31:24] at a, w_data[7:0] at a+3
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= 8'h00;
                mem3[i] <= 8'h00;
            end
            mem1[8'h40] <= 8'h11; mem1[8'h41] <= 8'h22; mem1[8'h42] <= 8'h33;
            mem1[8'h43] <= 8'h84; mem1[8'h44] <= 8'h55;
            mem3[8'h40] <= 8'h11; mem3[8'h41] <= 8'h22; mem3[8'h42] <= 8'h33;
            mem3[8'h43] <= 8'h84; mem3[8'h44] <= 8'h55;
        end else begin
            if (ctrl1 == 2'b01) begin
                mem1[addr1[7:0]]              <= wd1[31:24];
                mem1[8'(addr1[7:0] + 8'd1)]   <= wd1[23:16];
                mem1[8'(addr1[7:0] + 8'd2)]   <= wd1[15:8];
                mem1[8'(addr1[7:0] + 8'd3)]   <= wd1[7:0];
            end
            if (ctrl3 == 2'b01) begin
                mem3[addr3[7:0]]              <= wd3[31:24];
                mem3[8'(addr3[7:0] + 8'd1)]   <= wd3[23:16];
                mem3[8'(addr3[7:0] + 8'd2)]   <= wd3[15:8];
                mem3[8'(addr3[7:0] + 8'd3)]   <= wd3[7:0];
            end
        end
    end

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with the observed response
    task automatic got_resp(input int id, input logic [31:0] rd, input logic er);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_resp dut%0d: got resp_valid with rdata=%h, expected none", id, rd);
        end else begin
            e = sb.pop_front();
            chk_int($sformatf("op%0d_dut", e.tn), id, e.id);
            chk32($sformatf("op%0d_rdata", e.tn), rd, e.rdata);
            chk32($sformatf("op%0d_err", e.tn), {31'd0, er}, {31'd0, e.err});
            chk_int($sformatf("op%0d_latency", e.tn), cyc - e.t0, e.lat);
        end
    endtask

    // Monitor: responses, protocol invariants and command trace, sampled mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (rsp_v1 === 1'b1) got_resp(0, rsp_d1, err1);
            if (rsp_v3 === 1'b1) got_resp(1, rsp_d3, err3);
            if (ctrl1 == 2'b11 || ctrl3 == 2'b11) ctrl11_seen = 1'b1;
            if ((ctrl1 != 2'b00 && rdy1) || (ctrl3 != 2'b00 && rdy3)) busy_ready_seen = 1'b1;
            if (tr_on) trace.push_back((tr_sel == 0) ? ctrl1 : ctrl3);
        end
    end

    // Present a request, wait for acceptance, record the expectation; valid stays high
    task automatic issue(input int id, input int tn, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] erd, input logic eerr, input int elat,
                         input bit push);
        exp_t e;
        int   n;
        @(negedge clk);
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        if (id == 0) rv1 = 1'b1;
        else         rv3 = 1'b1;
        n = 0;
        while ((((id == 0) ? rdy1 : rdy3) !== 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL op%0d_accept: req_ready low for %0d cycles, expected high", tn, n);
        end else if (push) begin
            e.id    = id;
            e.tn    = tn;
            e.rdata = erd;
            e.err   = eerr;
            e.lat   = elat;
            e.t0    = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic drop();
        @(negedge clk);
        rv1 = 1'b0;
        rv3 = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL resp_timeout: %0d responses outstanding, expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // One traced request on the MEM_LAT=1 instance
    task automatic run1(input int tn, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] erd, input logic eerr, input int elat);
        trace.delete();
        tr_sel = 0;
        tr_on  = 1'b1;
        issue(0, tn, wr, sz, uns, a, wd, erd, eerr, elat, 1'b1);
        drop();
        wait_idle();
        tr_on = 1'b0;
    endtask

    // Split the command trace into non-idle runs and compare against expectation
    task automatic check_runs(input int tn, input int n_exp,
                              input logic [1:0] v0, input int l0,
                              input logic [1:0] v1, input int l1,
                              input int gmin, input int gmax);
        logic [1:0] rv [4];
        int         rl [4];
        int         rg [4];
        int         nr;
        logic [1:0] cur;
        int         len;
        int         zl;
        nr  = 0;
        cur = 2'b00;
        len = 0;
        zl  = 0;
        for (int i = 0; i <= trace.size(); i++) begin
            if (i == trace.size() || trace[i] != cur) begin
                if (cur != 2'b00) begin
                    if (nr < 4) begin
                        rv[nr] = cur;
                        rl[nr] = len;
                        rg[nr] = zl;
                    end
                    nr++;
                    zl = 0;
                end else begin
                    zl = len;
                end
                if (i < trace.size()) begin
                    cur = trace[i];
                    len = 1;
                end
            end else begin
                len++;
            end
        end
        chk_int($sformatf("op%0d_cmd_runs", tn), nr, n_exp);
        if (n_exp >= 1 && nr >= 1) begin
            chk32($sformatf("op%0d_cmd0", tn), {30'd0, rv[0]}, {30'd0, v0});
            chk_int($sformatf("op%0d_cmd0_len", tn), rl[0], l0);
        end
        if (n_exp >= 2 && nr >= 2) begin
            chk32($sformatf("op%0d_cmd1", tn), {30'd0, rv[1]}, {30'd0, v1});
            chk_int($sformatf("op%0d_cmd1_len", tn), rl[1], l1);
            total++;
            if (rg[1] < gmin || rg[1] > gmax) begin
                bad++;
                $display("FAIL op%0d_cmd_gap: got %0d idle cycles, expected %0d..%0d", tn, rg[1], gmin, gmax);
            end
        end
    endtask

    task automatic chk_reset1(input string tag);
        chk32({tag, "_req_ready"},  {31'd0, rdy1},   32'd1);
        chk32({tag, "_resp_valid"}, {31'd0, rsp_v1}, 32'd0);
        chk32({tag, "_resp_err"},   {31'd0, err1},   32'd0);
        chk32({tag, "_resp_rdata"}, rsp_d1,          32'd0);
        chk32({tag, "_ctrl"},       {30'd0, ctrl1},  32'd0);
        chk32({tag, "_address"},    addr1,           32'd0);
        chk32({tag, "_w_data"},     wd1,             32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc             = 0;
        total           = 0;
        bad             = 0;
        ctrl11_seen     = 1'b0;
        busy_ready_seen = 1'b0;
        tr_on           = 1'b0;
        tr_sel          = 0;
        reset_n         = 1'b0;
        tb_init         = 1'b1;
        rv1             = 1'b0;
        rv3             = 1'b0;
        req_write       = 1'b0;
        req_size        = 2'b00;
        req_unsigned    = 1'b0;
        req_addr        = 32'd0;
        req_wdata       = 32'd0;

        repeat (3) @(negedge clk);
        chk_reset1("reset");
        chk32("reset_dut3_req_ready", {31'd0, rdy3}, 32'd1);
        chk32("reset_dut3_ctrl", {30'd0, ctrl3}, 32'd0);
        tb_init = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Loads from preloaded 11 22 33 84 at 0x40
        run1(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h84332211, 1'b0, 2);
        check_runs(1, 1, 2'b10, 1, 2'b00, 0, 0, 0);
        run1(2, 1'b0, 2'b00, 1'b0, 32'h43, 32'h0, 32'hFFFFFF84, 1'b0, 2);
        run1(3, 1'b0, 2'b00, 1'b1, 32'h43, 32'h0, 32'h00000084, 1'b0, 2);
        run1(4, 1'b0, 2'b01, 1'b1, 32'h42, 32'h0, 32'h00008433, 1'b0, 2);
        run1(5, 1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 32'hFFFF8433, 1'b0, 2);

        // Word store
        run1(6, 1'b1, 2'b10, 1'b0, 32'h50, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        check_runs(6, 1, 2'b01, 1, 2'b00, 0, 0, 0);
        chk32("op6_w_data_held", wd1, 32'hEFBEADDE);
        chk32("op6_address_held", addr1, 32'h50);
        chk32("op6_mem", {mem1[8'h50], mem1[8'h51], mem1[8'h52], mem1[8'h53]}, 32'hEFBEADDE);

        // Byte store read-modify-write
        run1(7, 1'b1, 2'b00, 1'b0, 32'h40, 32'h000000AA, 32'h0, 1'b0, 4);
        check_runs(7, 2, 2'b10, 1, 2'b01, 1, 1, 1);
        chk32("op7_mem", {mem1[8'h40], mem1[8'h41], mem1[8'h42], mem1[8'h43]}, 32'hAA223384);

        // Misaligned word load
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        run1(8, 1'b0, 2'b10, 1'b0, 32'h41, 32'h0, 32'h0, 1'b1, 1);
        check_runs(8, 0, 2'b00, 0, 2'b00, 0, 0, 0);
`else
        run1(8, 1'b0, 2'b10, 1'b0, 32'h41, 32'h0, 32'h55843322, 1'b0, 2);
        check_runs(8, 1, 2'b10, 1, 2'b00, 0, 0, 0);
`endif

        // Half store RMW; upper store-data bits must be ignored
        run1(9, 1'b1, 2'b01, 1'b0, 32'h44, 32'hFFFF1234, 32'h0, 1'b0, 4);
        chk32("op9_mem", {mem1[8'h44], mem1[8'h45], mem1[8'h46], mem1[8'h47]}, 32'h34120000);
        run1(10, 1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 32'h00001234, 1'b0, 2);

        // Reset during the read phase of a byte store
        issue(0, 11, 1'b1, 2'b00, 1'b0, 32'h40, 32'h00000077, 32'h0, 1'b0, 0, 1'b0);
        @(negedge clk);
        rv1     = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_reset1("abort");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk32("op11_mem_unchanged", {mem1[8'h40], mem1[8'h41], mem1[8'h42], mem1[8'h43]}, 32'hAA223384);
        run1(12, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h843322AA, 1'b0, 2);

        // MEM_LAT=3: back-to-back LW then SW with req_valid held high
        trace.delete();
        tr_sel = 1;
        tr_on  = 1'b1;
        issue(1, 20, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h84332211, 1'b0, 4, 1'b1);
        issue(1, 21, 1'b1, 2'b10, 1'b0, 32'h60, 32'hCAFEF00D, 32'h0, 1'b0, 4, 1'b1);
        drop();
        wait_idle();
        tr_on = 1'b0;
        check_runs(21, 2, 2'b10, 3, 2'b01, 3, 1, 100);
        chk32("op21_mem", {mem3[8'h60], mem3[8'h61], mem3[8'h62], mem3[8'h63]}, 32'h0DF0FECA);

        // MEM_LAT=3: byte store RMW at an unaligned byte address
        trace.delete();
        tr_on = 1'b1;
        issue(1, 22, 1'b1, 2'b00, 1'b0, 32'h41, 32'h0000005A, 32'h0, 1'b0, 8, 1'b1);
        drop();
        wait_idle();
        tr_on = 1'b0;
        check_runs(22, 2, 2'b10, 3, 2'b01, 3, 1, 1);
        chk32("op22_mem", {mem3[8'h40], mem3[8'h41], mem3[8'h42], mem3[8'h43]}, 32'h115A3384);
        chk32("op22_mem_hi", {24'd0, mem3[8'h44]}, 32'h55);

        chk32("ctrl_never_11", {31'd0, ctrl11_seen}, 32'd0);
        chk32("ready_low_while_busy", {31'd0, busy_ready_seen}, 32'd0);
        chk_int("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
